lsb_agu: RTL and testbench

LSB_AGU -- requirements
Module: lsb_agu

---
 rtl/lsb_agu.sv | 76 +++++++
 tb/tb_lsb_agu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lsb_agu.sv
// lsb_agu: computes load/store/jalr addresses and queues them in a small in-order result FIFO
module lsb_agu #(
  parameter int ROB_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_vi,
  input  logic [11:0]      in_imm,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_funct3,
  input  logic [ROB_W-1:0] in_rob,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [1:0]       out_kind,
  output logic [2:0]       out_funct3,
  output logic [ROB_W-1:0] out_rob,
  output logic             out_misalign
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]      addr;
    logic [1:0]       kind;
    logic [2:0]       funct3;
    logic [ROB_W-1:0] rob;
    logic             mis;
  } ent_t;
  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  ent_t          new_e;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   sum;
  logic          jalr, enq, deq;
  always_comb begin
    sum = in_vi + {{20{in_imm[11]}}, in_imm};
    jalr = in_kind == 2'b10;
    new_e.addr = jalr ? {sum[31:1], 1'b0} : sum;
    new_e.kind = in_kind;
    new_e.funct3 = in_funct3;
    new_e.rob = in_rob;
    new_e.mis = !jalr && (in_funct3[1:0] == 2'b00 ? 1'b0 : in_funct3[1:0] == 2'b01 ? sum[0] : |sum[1:0]);
    enq = in_valid && in_ready && rdy_in && !flush;
    deq = out_valid && out_ready && rdy_in && !flush;
    mem_d = mem_q;
    mem_d[tail_q] = enq ? new_e : mem_q[tail_q];
    head_d = flush ? '0 : head_q + PW'(deq);
    tail_d = flush ? '0 : tail_q + PW'(enq);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
  end
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
    end
  end
  // DEPTH is a power of two, so the counter MSB alone marks a full queue
  assign in_ready = !cnt_q[PW];
  assign out_valid = cnt_q != '0;
  assign out_addr = out_valid ? mem_q[head_q].addr : '0;
  assign out_kind = out_valid ? mem_q[head_q].kind : '0;
  assign out_funct3 = out_valid ? mem_q[head_q].funct3 : '0;
  assign out_rob = out_valid ? mem_q[head_q].rob : '0;
  assign out_misalign = out_valid ? mem_q[head_q].mis : 1'b0;
endmodule

// File: tb/tb_lsb_agu.sv
// tb_lsb_agu: directed and randomized checks of lsb_agu against a queue-based reference model
module tb_lsb_agu;
  localparam int ROB_W = 4;
  localparam int DEPTH = 4;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush, in_valid, in_ready, out_valid, out_ready, out_misalign;
  logic [31:0] in_vi, out_addr;
  logic [11:0] in_imm;
  logic [1:0] in_kind, out_kind;
  logic [2:0] in_funct3, out_funct3;
  logic [ROB_W-1:0] in_rob, out_rob;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0]      addr;
    logic [1:0]       kind;
    logic [2:0]       f3;
    logic [ROB_W-1:0] rob;
    logic             mis;
  } ent_t;
  ent_t mq[$];

  always #5 clk_in = ~clk_in;

  lsb_agu #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_vi(in_vi), .in_imm(in_imm),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_rob(in_rob),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_kind(out_kind), .out_funct3(out_funct3), .out_rob(out_rob),
    .out_misalign(out_misalign)
  );

  function automatic ent_t ref_ent();
    ent_t e;
    int sx;
    int unsigned bytes;
    sx = $signed(in_imm);
    e.addr = in_vi + 32'(sx);
    if (in_kind == 2'd2) e.addr = e.addr - (e.addr % 2);
    bytes = in_funct3[1:0] == 2'd0 ? 1 : in_funct3[1:0] == 2'd1 ? 2 : 4;
    e.mis = (in_kind != 2'd2) && (e.addr % bytes != 0);
    e.kind = in_kind;
    e.f3 = in_funct3;
    e.rob = in_rob;
    return e;
  endfunction

  task automatic tick();
    bit enq, deq;
    ent_t e, d;
    enq = in_valid && mq.size() < DEPTH && rdy_in && !flush;
    deq = mq.size() > 0 && out_ready && rdy_in && !flush;
    e = ref_ent();
    @(posedge clk_in);
    #1;
    if (rst_in || flush) mq.delete();
    else begin
      if (deq) d = mq.pop_front();
      if (enq) mq.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] vi, input logic [11:0] imm,
                       input logic [1:0] k, input logic [2:0] f3, input logic [ROB_W-1:0] rob);
    in_valid = v; in_vi = vi; in_imm = imm; in_kind = k; in_funct3 = f3; in_rob = rob;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; flush = 1'b1; rdy_in = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h1234, 12'h10, 2'd0, 3'd2, 4'd1);
    tick(); tick();
    rst_in = 1'b0; flush = 1'b0; rdy_in = 1'b1; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_addr !== 32'h0 || out_misalign !== 1'b0 || out_rob !== '0)
      begin n_fail++; $display("FAIL reset_payload got addr=%h mis=%b rob=%h want 0", out_addr, out_misalign, out_rob); end
  endtask

  task automatic test_directed();
    logic [31:0] vis [6] = '{32'h00001000, 32'h00002003, 32'hFFFFFFFF, 32'h101, 32'h102, 32'h103};
    logic [11:0] imms [6] = '{12'hFFC, 12'h002, 12'h001, 12'h000, 12'h000, 12'h000};
    logic [1:0] kinds [6] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
    logic [2:0] f3s [6] = '{3'b010, 3'b000, 3'b000, 3'b001, 3'b010, 3'b000};
    logic [31:0] eaddr [6] = '{32'h00000FFC, 32'h00002004, 32'h0, 32'h101, 32'h102, 32'h103};
    logic emis [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b0;
      drive(1'b1, vis[i], imms[i], kinds[i], f3s[i], ROB_W'(i + 3));
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_addr !== eaddr[i] || out_misalign !== emis[i] || out_rob !== ROB_W'(i + 3) || out_kind !== kinds[i])
        begin n_fail++; $display("FAIL directed_%0d got v=%b addr=%h mis=%b rob=%h kind=%h want v=1 addr=%h mis=%b rob=%h kind=%h",
          i, out_valid, out_addr, out_misalign, out_rob, out_kind, eaddr[i], emis[i], ROB_W'(i + 3), kinds[i]); end
      out_ready = 1'b1;
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_deq_%0d got out_valid=%b want 0", i, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, $urandom, 12'($urandom), 2'd1, 3'd0, ROB_W'(i));
      tick();
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    drive(1'b1, 32'h0, 12'h0, 2'd0, 3'd0, 4'hF);
    tick(); tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || out_rob !== '0) begin n_fail++; $display("FAIL full_extra got ready=%b rob=%h want ready=0 rob=0", in_ready, out_rob); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_rob !== ROB_W'(i) || out_addr !== mq[0].addr)
        begin n_fail++; $display("FAIL drain_%0d got v=%b rob=%h addr=%h want v=1 rob=%h addr=%h", i, out_valid, out_rob, out_addr, ROB_W'(i), mq[0].addr); end
      tick();
    end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL drained got v=%b ready=%b want v=0 ready=1", out_valid, in_ready); end
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, $urandom, 12'($urandom), 2'd0, 3'd2, ROB_W'(i + 8));
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_rob !== ROB_W'(9))
      begin n_fail++; $display("FAIL full_no_bypass got ready=%b rob=%h want ready=1 rob=9", in_ready, out_rob); end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 12'($urandom), 2'd0, 3'd0, ROB_W'(i + 1));
      tick();
    end
    drive(1'b1, 32'h40, 12'h0, 2'd0, 3'd0, 4'hA);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush got v=%b ready=%b want v=0 ready=1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_%0d got v=%b want 0", i, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] a;
    logic [ROB_W-1:0] r;
    out_ready = 1'b0;
    drive(1'b1, 32'h00003000, 12'h7FE, 2'd0, 3'd1, 4'h6);
    tick();
    a = mq[0].addr; r = mq[0].rob;
    drive(1'b1, 32'h5555, 12'h1, 2'd1, 3'd2, 4'h2);
    rdy_in = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_addr !== a || out_rob !== r || in_ready !== 1'b1)
        begin n_fail++; $display("FAIL stall_%0d got v=%b addr=%h rob=%h ready=%b want v=1 addr=%h rob=%h ready=1", i, out_valid, out_addr, out_rob, in_ready, a, r); end
    end
    rdy_in = 1'b1; in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got v=%b want 0", out_valid); end
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 12'h0, 2'd0, 3'd0, 4'h1);
    tick();
    rdy_in = 1'b0; flush = 1'b1; in_valid = 1'b0;
    tick();
    rdy_in = 1'b1; flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_while_paused got v=%b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 12'($urandom), 2'd0, 3'd0, ROB_W'(i));
      tick();
    end
    rst_in = 1'b1; in_valid = 1'b0;
    tick();
    rst_in = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid got v=%b ready=%b want v=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 12'($urandom), 2'($urandom), 3'($urandom), ROB_W'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      rdy_in = $urandom_range(0, 7) != 0;
      flush = $urandom_range(0, 49) == 0;
      rst_in = $urandom_range(0, 99) == 0;
      tick();
      n_checks++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH))
        begin n_fail++; $display("FAIL rand_%0d_flags got v=%b ready=%b want v=%b ready=%b", i, out_valid, in_ready, mq.size() > 0, mq.size() < DEPTH); end
      if (mq.size() > 0) begin
        n_checks++; if (out_addr !== mq[0].addr || out_misalign !== mq[0].mis || out_kind !== mq[0].kind || out_funct3 !== mq[0].f3 || out_rob !== mq[0].rob)
          begin n_fail++; $display("FAIL rand_%0d_payload got addr=%h mis=%b kind=%h f3=%h rob=%h want addr=%h mis=%b kind=%h f3=%h rob=%h",
            i, out_addr, out_misalign, out_kind, out_funct3, out_rob, mq[0].addr, mq[0].mis, mq[0].kind, mq[0].f3, mq[0].rob); end
      end
    end
    rst_in = 1'b0; flush = 1'b0; rdy_in = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full();
    test_flush();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
